cpu_regseq: RTL

- Initiator-side sequencer for the Intel8008 CPU register bank.
- Accepts one decoded register-class opcode per START_I pulse: MOV r1,r2, MVI r,imm, INR r and DCR r.
- Issues the matching CS/RD/WR/INC/DCR/SYNC/ADDR/DAT cycles to the bank and reports completion.
- Sits between the instruction decoder and the bank; CLK_I is the same clock that clocks the bank's write port.

---
 rtl/cpu_regseq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_regseq.sv
// ============================================================================
// Module   : cpu_regseq
// Purpose  : Initiator-side sequencer driving the 8008 register bank for
//            MOV r1,r2 / MVI r,imm / INR r / DCR r.
//            Optional macro CPU_REGSEQ_FLAGS_EN adds INR/DCR read-back flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_regseq #(
  parameter int   DW        = 8,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          START_I,
  input  logic [7:0]    OPCODE_I,
  input  logic [DW-1:0] IMM_I,
  input  logic [DW-1:0] BANK_DAT_I,
  output logic          BANK_CS_O,
  output logic          BANK_RD_O,
  output logic          BANK_WR_O,
  output logic          BANK_INC_O,
  output logic          BANK_DCR_O,
  output logic          BANK_SYNC_O,
  output logic [2:0]    BANK_ADDR_O,
  output logic [DW-1:0] BANK_DAT_O,
  output logic          BUSY_O,
  output logic          DONE_O,
  output logic          ILLEGAL_O,
  output logic          FLAG_Z_O,
  output logic          FLAG_S_O,
  output logic          FLAG_P_O
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_WRITE    = 3'd2,
    S_INCDEC   = 3'd3,
    S_READBACK = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t     r_state;
  logic [2:0] r_ddd;

  logic [2:0] w_ddd;
  logic [2:0] w_sss;
  logic       w_is_mov;
  logic       w_is_mvi;
  logic       w_is_inr;
  logic       w_is_dcr;

  // Register index 111 addresses memory (M), and INR/DCR A collide with HLT.
  assign w_ddd    = OPCODE_I[5:3];
  assign w_sss    = OPCODE_I[2:0];
  assign w_is_mov = (OPCODE_I[7:6] == 2'b11) && (w_ddd != 3'b111) && (w_sss != 3'b111);
  assign w_is_mvi = (OPCODE_I[7:6] == 2'b00) && (w_sss == 3'b110) && (w_ddd != 3'b111);
  assign w_is_inr = (OPCODE_I[7:6] == 2'b00) && (w_sss == 3'b000) &&
                    (w_ddd != 3'b000) && (w_ddd != 3'b111);
  assign w_is_dcr = (OPCODE_I[7:6] == 2'b00) && (w_sss == 3'b001) &&
                    (w_ddd != 3'b000) && (w_ddd != 3'b111);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state     <= S_IDLE;
      r_ddd       <= 3'd0;
      BANK_CS_O   <= 1'b0;
      BANK_RD_O   <= 1'b0;
      BANK_WR_O   <= 1'b0;
      BANK_INC_O  <= 1'b0;
      BANK_DCR_O  <= 1'b0;
      BANK_SYNC_O <= SYNC_IDLE;
      BANK_ADDR_O <= 3'd0;
      BANK_DAT_O  <= '0;
      BUSY_O      <= 1'b0;
      DONE_O      <= 1'b0;
      ILLEGAL_O   <= 1'b0;
`ifdef CPU_REGSEQ_FLAGS_EN
      FLAG_Z_O    <= 1'b0;
      FLAG_S_O    <= 1'b0;
      FLAG_P_O    <= 1'b0;
`endif
    end else begin
      BANK_CS_O   <= 1'b0;
      BANK_RD_O   <= 1'b0;
      BANK_WR_O   <= 1'b0;
      BANK_INC_O  <= 1'b0;
      BANK_DCR_O  <= 1'b0;
      BANK_SYNC_O <= SYNC_IDLE;
      DONE_O      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START_I) begin
            r_ddd     <= w_ddd;
            ILLEGAL_O <= 1'b0;
            if (w_is_mov) begin
              r_state     <= S_READ;
              BUSY_O      <= 1'b1;
              BANK_CS_O   <= 1'b1;
              BANK_RD_O   <= 1'b1;
              BANK_ADDR_O <= w_sss;
            end else if (w_is_mvi) begin
              r_state     <= S_WRITE;
              BUSY_O      <= 1'b1;
              BANK_CS_O   <= 1'b1;
              BANK_WR_O   <= 1'b1;
              BANK_SYNC_O <= 1'b0;
              BANK_ADDR_O <= w_ddd;
              BANK_DAT_O  <= IMM_I;
            end else if (w_is_inr || w_is_dcr) begin
              r_state     <= S_INCDEC;
              BUSY_O      <= 1'b1;
              BANK_CS_O   <= 1'b1;
              BANK_INC_O  <= w_is_inr;
              BANK_DCR_O  <= w_is_dcr;
              BANK_SYNC_O <= 1'b0;
              BANK_ADDR_O <= w_ddd;
            end else begin
              r_state   <= S_DONE;
              DONE_O    <= 1'b1;
              ILLEGAL_O <= 1'b1;
            end
          end
        end
        S_READ: begin
          // BANK_DAT_O doubles as the MOV data latch.
          r_state     <= S_WRITE;
          BANK_CS_O   <= 1'b1;
          BANK_WR_O   <= 1'b1;
          BANK_SYNC_O <= 1'b0;
          BANK_ADDR_O <= r_ddd;
          BANK_DAT_O  <= BANK_DAT_I;
        end
        S_WRITE: begin
          r_state <= S_DONE;
          DONE_O  <= 1'b1;
          BUSY_O  <= 1'b0;
        end
        S_INCDEC: begin
`ifdef CPU_REGSEQ_FLAGS_EN
          r_state     <= S_READBACK;
          BANK_CS_O   <= 1'b1;
          BANK_RD_O   <= 1'b1;
          BANK_ADDR_O <= r_ddd;
`else
          r_state <= S_DONE;
          DONE_O  <= 1'b1;
          BUSY_O  <= 1'b0;
`endif
        end
`ifdef CPU_REGSEQ_FLAGS_EN
        S_READBACK: begin
          r_state  <= S_DONE;
          DONE_O   <= 1'b1;
          BUSY_O   <= 1'b0;
          FLAG_Z_O <= (BANK_DAT_I == '0);
          FLAG_S_O <= BANK_DAT_I[DW-1];
          FLAG_P_O <= ~^BANK_DAT_I;
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          BUSY_O  <= 1'b0;
        end
      endcase
    end
  end

`ifndef CPU_REGSEQ_FLAGS_EN
  assign FLAG_Z_O = 1'b0;
  assign FLAG_S_O = 1'b0;
  assign FLAG_P_O = 1'b0;
`endif

endmodule

`default_nettype wire
